// File: rtl/mem_pkg.sv
// Shared widths and types for the dual-read, single-write word memory.
package mem_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned WADDR_W = 30;
    localparam int unsigned NBYTES  = XLEN / 8;

    typedef logic [XLEN-1:0]    word_t;
    typedef logic [WADDR_W-1:0] waddr_t;
    typedef logic [NBYTES-1:0]  byte_en_t;

endpackage : mem_pkg

// File: rtl/mem_if.sv
// Bundles the memory's read and write port signals.
// Master drives addresses and write data, slave returns read data.
interface mem_if;
    import mem_pkg::*;

    waddr_t   r1_addr;
    word_t    r1_val;
    waddr_t   r2_addr;
    word_t    r2_val;
    logic     w_enable;
    waddr_t   w_addr;
    word_t    w_val;
    byte_en_t byte_en;

    modport master (
        output r1_addr, r2_addr, w_enable, w_addr, w_val, byte_en,
        input  r1_val, r2_val
    );

    modport slave (
        input  r1_addr, r2_addr, w_enable, w_addr, w_val, byte_en,
        output r1_val, r2_val
    );

endinterface : mem_if

// File: rtl/mem_byte_merge.sv
// Merges a new word into an old word, lane by lane, under a byte mask.
module byte_merge
    import mem_pkg::*;
(
    input  word_t    old_i,
    input  word_t    new_i,
    input  byte_en_t mask_i,
    output word_t    merged_o
);

    // Each enabled lane takes the new byte; disabled lanes keep the old one.
    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < int'(NBYTES); i++) begin
            if (mask_i[i]) begin
                merged_o[8*i +: 8] = new_i[8*i +: 8];
            end
        end
    end

endmodule : byte_merge

// File: rtl/mem.sv
// Word memory with two combinational read ports and one byte-masked write port.
// Storage is a flop array so it can be cleared asynchronously by rst.
module mem
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic     clk,
    input  waddr_t   r1_addr,
    output word_t    r1_val,
    input  waddr_t   r2_addr,
    output word_t    r2_val,
    input  logic     w_enable,
    input  waddr_t   w_addr,
    input  word_t    w_val,
    input  byte_en_t byte_en,
    input  logic     rst
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] idx_t;

    word_t mem_q [Depth];
    word_t merged;
    idx_t  w_idx;
    idx_t  r1_idx;
    idx_t  r2_idx;

    // High address bits are dropped, so addresses alias modulo the depth.
    assign w_idx  = w_addr[DEPTH_LOG2-1:0];
    assign r1_idx = r1_addr[DEPTH_LOG2-1:0];
    assign r2_idx = r2_addr[DEPTH_LOG2-1:0];

    if (DEPTH_LOG2 < WADDR_W) begin : g_unused_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^{w_addr[WADDR_W-1:DEPTH_LOG2],
                                  r1_addr[WADDR_W-1:DEPTH_LOG2],
                                  r2_addr[WADDR_W-1:DEPTH_LOG2]};
    end

    byte_merge u_byte_merge (
        .old_i    (mem_q[w_idx]),
        .new_i    (w_val),
        .mask_i   (byte_en),
        .merged_o (merged)
    );

    // Async clear on rst; otherwise merge the masked write into the addressed word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_enable) begin
            mem_q[w_idx] <= merged;
        end
    end

    // Reads are zero-latency and see the stored word only (no w_val bypass).
    assign r1_val = mem_q[r1_idx];
    assign r2_val = mem_q[r2_idx];

endmodule : mem

// File: tb/tb_mem.sv
// Self-checking bench for mem: directed scenarios plus randomized writes/reads
// compared against a word-array reference model.
module tb_mem;
    import mem_pkg::*;

    localparam int unsigned DepthLog2 = 10;
    localparam int unsigned Depth     = 2 ** DepthLog2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_if bus ();

    mem #(.DEPTH_LOG2(DepthLog2)) dut (
        .clk      (clk),
        .r1_addr  (bus.r1_addr),
        .r1_val   (bus.r1_val),
        .r2_addr  (bus.r2_addr),
        .r2_val   (bus.r2_val),
        .w_enable (bus.w_enable),
        .w_addr   (bus.w_addr),
        .w_val    (bus.w_val),
        .byte_en  (bus.byte_en),
        .rst      (rst)
    );

    always #5 clk = ~clk;

    int    n_cmp  = 0;
    int    n_fail = 0;
    word_t model [Depth];

    function automatic word_t apply_mask(word_t old, word_t nw, logic [3:0] be);
        word_t m = '0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m = m | (32'hFF << (8 * i));
        end
        return (old & ~m) | (nw & m);
    endfunction

    function automatic int unsigned idx_of(waddr_t a);
        return int'(a) % Depth;
    endfunction

    task automatic check(input string tag, input word_t obs, input word_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(Depth); i++) model[i] = '0;
    endtask

    // One write cycle: drive at negedge, update the model at the edge, drop w_enable.
    task automatic do_write(input logic en, input waddr_t a, input word_t v,
                            input logic [3:0] be);
        @(negedge clk);
        bus.w_enable = en;
        bus.w_addr   = a;
        bus.w_val    = v;
        bus.byte_en  = be;
        @(posedge clk);
        if (en && !rst) model[idx_of(a)] = apply_mask(model[idx_of(a)], v, be);
        #1;
        bus.w_enable = 1'b0;
    endtask

    task automatic read_both(input string tag, input waddr_t a1, input waddr_t a2);
        bus.r1_addr = a1;
        bus.r2_addr = a2;
        #1;
        check({tag, "_r1"}, bus.r1_val, model[idx_of(a1)]);
        check({tag, "_r2"}, bus.r2_val, model[idx_of(a2)]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.r1_addr  = '0;
        bus.r2_addr  = '0;
        bus.w_enable = 1'b0;
        bus.w_addr   = '0;
        bus.w_val    = '0;
        bus.byte_en  = '0;
        clear_model();

        // Reset: a write attempted under reset must not land.
        bus.w_enable = 1'b1;
        bus.w_addr   = 30'h3;
        bus.w_val    = 32'hFFFF_FFFF;
        bus.byte_en  = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        bus.w_enable = 1'b0;
        bus.r1_addr  = 30'h3;
        bus.r2_addr  = 30'h0;
        #1;
        check("reset_r1", bus.r1_val, 32'h0);
        check("reset_r2", bus.r2_val, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Full write, then aliased read.
        do_write(1'b1, 30'h7000, 32'hDEAD_BEEF, 4'b1111);
        bus.r1_addr = 30'h7000;
        #1;
        check("full_write", bus.r1_val, 32'hDEAD_BEEF);
        bus.r2_addr = 30'h0;
        #1;
        check("alias_7000_idx0", bus.r2_val, 32'hDEAD_BEEF);

        do_write(1'b1, 30'h7000, 32'h0000_C0DE, 4'b0011);
        #1;
        check("partial_write", bus.r1_val, 32'hDEAD_C0DE);

        do_write(1'b0, 30'h7000, 32'hFFFF_FFFF, 4'b1111);
        #1;
        check("disabled_write", bus.r1_val, 32'hDEAD_C0DE);
        do_write(1'b1, 30'h7000, 32'hFFFF_FFFF, 4'b0000);
        #1;
        check("empty_mask", bus.r1_val, 32'hDEAD_C0DE);

        // Dual read with aliasing.
        do_write(1'b1, 30'd5, 32'h1234_5678, 4'b1111);
        bus.r1_addr = 30'd5;
        bus.r2_addr = 30'(5 + Depth);
        #1;
        check("dual_r1", bus.r1_val, 32'h1234_5678);
        check("dual_r2", bus.r2_val, 32'h1234_5678);

        // Read-during-write: old word before the edge, merged word after.
        @(negedge clk);
        bus.w_enable = 1'b1;
        bus.w_addr   = 30'd5;
        bus.w_val    = 32'hFFFF_FF99;
        bus.byte_en  = 4'b0001;
        #1;
        check("rdw_before", bus.r1_val, 32'h1234_5678);
        @(posedge clk);
        #1;
        bus.w_enable = 1'b0;
        model[5] = apply_mask(model[5], 32'hFFFF_FF99, 4'b0001);
        check("rdw_after_r1", bus.r1_val, 32'h1234_5699);
        check("rdw_after_r2", bus.r2_val, 32'h1234_5699);

        // Single-lane masks on a zero word.
        do_write(1'b1, 30'd9, 32'hAABB_CCDD, 4'b1000);
        bus.r1_addr = 30'd9;
        #1;
        check("lane3", bus.r1_val, 32'hAA00_0000);
        do_write(1'b1, 30'd9, 32'hAABB_CCDD, 4'b0100);
        #1;
        check("lane2", bus.r1_val, 32'hAABB_0000);

        // Randomized writes over a small aliased window, checked on both ports.
        for (int n = 0; n < 300; n++) begin
            waddr_t wa;
            wa = waddr_t'(($urandom() & 32'h3FFF_FC00) | $urandom_range(0, 15));
            do_write(($urandom_range(0, 3) != 0), wa, word_t'($urandom()),
                     4'($urandom_range(0, 15)));
            read_both("rand",
                      waddr_t'(($urandom() & 32'h3FFF_FC00) | $urandom_range(0, 15)),
                      ($urandom_range(0, 1) == 1) ? wa : waddr_t'($urandom_range(0, 15)));
        end

        // Async reset between edges clears everything immediately.
        do_write(1'b1, 30'h7000, 32'hCAFE_F00D, 4'b1111);
        bus.r1_addr = 30'h7000;
        bus.r2_addr = 30'd9;
        @(negedge clk);
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        check("async_rst_r1", bus.r1_val, 32'h0);
        check("async_rst_r2", bus.r2_val, 32'h0);
        do_write(1'b1, 30'h7000, 32'h5555_AAAA, 4'b1111);
        #1;
        check("write_in_rst", bus.r1_val, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        do_write(1'b1, 30'h7000, 32'h0BAD_F00D, 4'b1111);
        #1;
        check("first_after_rst", bus.r1_val, 32'h0BAD_F00D);
        read_both("post_rst", 30'h7000, 30'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mem

// File: doc/mem.md
MEM -- requirements
Module: mem

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, SHALL set storage to 2^DEPTH_LOG2 32-bit words.
REQ-002 clk  input  1  single clock; all writes occur on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 r1_addr  input  30  read port 1 word address (byte address bits [31:2]).
REQ-005 r1_val  output  32  read port 1 data.
REQ-006 r2_addr  input  30  read port 2 word address.
REQ-007 r2_val  output  32  read port 2 data.
REQ-008 w_enable  input  1  write strobe, sampled at rising clk.
REQ-009 w_addr  input  30  write word address.
REQ-010 w_val  input  32  write data.
REQ-011 byte_en  input  4  per-byte write mask; bit i enables w_val[8i+7:8i].
REQ-012 Positional port order SHALL be clk, r1_addr, r1_val, r2_addr, r2_val, w_enable, w_addr, w_val, byte_en, rst, so that existing positional instantiations of the first nine ports remain valid.

Function
REQ-013 Each read port SHALL be combinational: rN_val = word[rN_addr[DEPTH_LOG2-1:0]], zero latency, with both ports independent.
REQ-014 Address bits above DEPTH_LOG2-1 SHALL be ignored, so out-of-range addresses alias modulo the depth (e.g. 0x7000 maps to index 0 at the default depth).
REQ-015 On a rising clk edge with w_enable=1 and rst=0, each byte lane i with byte_en[i]=1 SHALL take w_val[8i+7:8i]; lanes with byte_en[i]=0 SHALL keep their old value.
REQ-016 w_enable=1 with byte_en=4'b0000 SHALL leave memory unchanged.
REQ-017 w_enable=0 SHALL leave memory unchanged regardless of the other write inputs.
REQ-018 Read-during-write to the same address: before the edge, rN_val SHALL show the old word; after the edge, it SHALL show the merged word within the same cycle, with no bypass of w_val.
REQ-019 Both read ports addressing the write location SHALL observe identical data.
REQ-020 Byte enables SHALL impose no alignment rule; any of the 16 mask patterns is legal.

Reset
REQ-021 While rst=1, every word SHALL be forced to 32'h0 asynchronously, and r1_val/r2_val SHALL read 0.
REQ-022 Writes SHALL be ignored on any clk edge where rst=1.
REQ-023 After rst deasserts, the first write SHALL occur on the next rising clk edge with w_enable=1.
REQ-024 Assertion of rst mid-sequence SHALL discard all previously written data.

Structure
REQ-025 Shared package mem_pkg SHALL hold XLEN=32, WADDR_W=30 and NBYTES=4, plus the typedefs word_t (32 bits) and waddr_t (30 bits).
REQ-026 The block SHALL be one module holding a register array with a per-byte-lane write loop; an optional sub-module byte_merge (old word, new word, mask -> merged word) MAY be used, and no other hierarchy is needed.
REQ-027 The storage SHALL be a flop array, because of the asynchronous clear; it SHALL NOT be inferred as SRAM.

Verification
REQ-028 Reset, then full write: w_addr=0x7000, byte_en=1111, w_val=DEADBEEF, one edge; then r1_addr=0x7000 -> r1_val=DEADBEEF.
REQ-029 Partial write: same address, byte_en=0011, w_val=0000C0DE -> r1_val=DEADC0DE.
REQ-030 Disabled and empty-mask writes: w_enable=0 with w_val=FFFFFFFF, then w_enable=1 with byte_en=0000 -> word unchanged (DEADC0DE).
REQ-031 Dual read and aliasing: write 12345678 to address 5; r1_addr=5 and r2_addr=5+2^DEPTH_LOG2 -> both ports read 12345678.
REQ-032 Async reset mid-cycle: assert rst between edges -> r1_val=0 immediately; a write attempted while rst=1 does not land.
REQ-033 Single-lane masks: byte_en=1000 then 0100 on a zero word with w_val=AABBCCDD -> word reads AA000000, then AABB0000.
